uart_byte_rx: RTL and testbench

- Asynchronous serial receiver (8N1, LSB first) that turns the board UART line into the `data[7:0]` / `data_valid` pair consumed by the tone generator.
- Sits directly upstream of the tone generator.
- Holds the last good byte stable and emits a single-cycle `data_valid` pulse per good frame. The tone generator's rising-edge detect therefore retriggers once per received byte.

---
 rtl/synth_pkg.sv | 17 +
 rtl/sync_ff.sv | 24 ++
 rtl/uart_byte_rx.sv | 134 +++++++++++++
 tb/tb_uart_byte_rx.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and default timing constants for the UART receive path
package synth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int CLK_HZ       = 25_000_000;
    localparam int BAUD         = 115_200;
    // Rounded to the nearest whole clock: 25 MHz / 115200 = 217.01 -> 217.
    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - N-flop synchronizer for asynchronous board inputs, resets to 1
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    // Shift the raw input through N flops; reset high so an idle line reads idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '1;
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 LSB-first serial receiver producing data/data_valid
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = synth_pkg::CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    import synth_pkg::*;

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic          rx_s;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          dv_q, dv_d;
    logic          fe_q, fe_d;

    sync_ff #(.N(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // State and datapath registers; reset discards any partial byte and clears data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
        end
    end

    // Next-state logic: start bit is re-checked at its centre, then every bit sampled one period later.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF) begin
                    if (!rx_s) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        // Line went back high before the centre: treat as a glitch.
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Back to IDLE at the stop-bit centre so an immediate next start is caught.
                        data_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                // Wait out a held-low line so it yields only one frame error.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - scoreboard bench for uart_byte_rx at 16 and 217 clocks per bit
module tb_uart_byte_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       dv_a, dv_b, fe_a, fe_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int dv_cnt_a = 0, fe_cnt_a = 0, dv_cnt_b = 0, fe_cnt_b = 0;
    int last_dv_cyc_a = 0, prev_dv_cyc_a = 0;
    int start_cyc_a = 0;
    logic prev_pulse_a = 1'b0, prev_pulse_b = 1'b0;

    uart_byte_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx_a),
        .data       (data_a),
        .data_valid (dv_a),
        .frame_err  (fe_a),
        .busy       (busy_a)
    );

    uart_byte_rx dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx_b),
        .data       (data_b),
        .data_valid (dv_b),
        .frame_err  (fe_b),
        .busy       (busy_b)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        logic [7:0] e;
        if (dv_a) begin
            n_cmp++;
            if (q_a.size() == 0) begin
                n_bad++;
                $display("FAIL sb_a_unexpected got=%h expected=none", data_a);
            end else begin
                e = q_a.pop_front();
                if (data_a !== e) begin
                    n_bad++;
                    $display("FAIL sb_a_data got=%h expected=%h", data_a, e);
                end
            end
            dv_cnt_a++;
            prev_dv_cyc_a = last_dv_cyc_a;
            last_dv_cyc_a = cyc;
        end
        if (fe_a) fe_cnt_a++;
        if (dv_a || fe_a) begin
            n_cmp++;
            if ((dv_a && fe_a) || prev_pulse_a) begin
                n_bad++;
                $display("FAIL pulse_a_excl got dv=%b fe=%b prev=%b expected single", dv_a, fe_a, prev_pulse_a);
            end
        end
        prev_pulse_a = dv_a || fe_a;

        if (dv_b) begin
            n_cmp++;
            if (q_b.size() == 0) begin
                n_bad++;
                $display("FAIL sb_b_unexpected got=%h expected=none", data_b);
            end else begin
                e = q_b.pop_front();
                if (data_b !== e) begin
                    n_bad++;
                    $display("FAIL sb_b_data got=%h expected=%h", data_b, e);
                end
            end
            dv_cnt_b++;
        end
        if (fe_b) fe_cnt_b++;
        if (dv_b || fe_b) begin
            n_cmp++;
            if ((dv_b && fe_b) || prev_pulse_b) begin
                n_bad++;
                $display("FAIL pulse_b_excl got dv=%b fe=%b prev=%b expected single", dv_b, fe_b, prev_pulse_b);
            end
        end
        prev_pulse_b = dv_b || fe_b;
    end

    task automatic hold_bit(input int period);
        repeat (period) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; caller must be aligned 1 time unit after a posedge.
    task automatic send_a(input logic [7:0] b, input int period, input logic stop);
        if (stop) q_a.push_back(b);
        start_cyc_a = cyc;
        rx_a = 1'b0;
        hold_bit(period);
        for (int i = 0; i < 8; i++) begin
            rx_a = b[i];
            hold_bit(period);
        end
        rx_a = stop;
        hold_bit(period);
    endtask

    task automatic send_b(input logic [7:0] b, input int period);
        q_b.push_back(b);
        rx_b = 1'b0;
        hold_bit(period);
        for (int i = 0; i < 8; i++) begin
            rx_b = b[i];
            hold_bit(period);
        end
        rx_b = 1'b1;
        hold_bit(period);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({data_a, dv_a, fe_a, busy_a} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_a got data=%h dv=%b fe=%b busy=%b expected 00 0 0 0", data_a, dv_a, fe_a, busy_a);
        end
        n_cmp++;
        if ({data_b, dv_b, fe_b, busy_b} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_b got data=%h dv=%b fe=%b busy=%b expected 00 0 0 0", data_b, dv_b, fe_b, busy_b);
        end
        rst_n = 1'b1;
        hold_bit(5);
    endtask

    task automatic test_single;
        int fe0;
        fe0 = fe_cnt_a;
        send_a(8'h3C, 16, 1'b1);
        hold_bit(20);
        n_cmp++;
        if (data_a !== 8'h3C) begin
            n_bad++;
            $display("FAIL single_data got=%h expected=3c", data_a);
        end
        n_cmp++;
        if (last_dv_cyc_a - start_cyc_a != 155) begin
            n_bad++;
            $display("FAIL single_latency got=%0d expected=155", last_dv_cyc_a - start_cyc_a);
        end
        n_cmp++;
        if (fe_cnt_a != fe0) begin
            n_bad++;
            $display("FAIL single_fe got=%0d expected=0", fe_cnt_a - fe0);
        end
    endtask

    task automatic test_back_to_back;
        int dv0;
        dv0 = dv_cnt_a;
        send_a(8'h00, 16, 1'b1);
        send_a(8'hFF, 16, 1'b1);
        hold_bit(20);
        n_cmp++;
        if (dv_cnt_a - dv0 != 2) begin
            n_bad++;
            $display("FAIL b2b_count got=%0d expected=2", dv_cnt_a - dv0);
        end
        n_cmp++;
        if (last_dv_cyc_a - prev_dv_cyc_a != 160) begin
            n_bad++;
            $display("FAIL b2b_spacing got=%0d expected=160", last_dv_cyc_a - prev_dv_cyc_a);
        end
        n_cmp++;
        if (data_a !== 8'hFF) begin
            n_bad++;
            $display("FAIL b2b_data got=%h expected=ff", data_a);
        end
    endtask

    task automatic test_glitch;
        int dv0, fe0;
        logic saw_busy;
        dv0 = dv_cnt_a;
        fe0 = fe_cnt_a;
        saw_busy = 1'b0;
        rx_a = 1'b0;
        hold_bit(5);
        rx_a = 1'b1;
        for (int i = 0; i < 30; i++) begin
            hold_bit(1);
            if (busy_a) saw_busy = 1'b1;
        end
        n_cmp++;
        if (saw_busy !== 1'b1 || busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_busy got saw=%b now=%b expected 1 0", saw_busy, busy_a);
        end
        n_cmp++;
        if (dv_cnt_a != dv0 || fe_cnt_a != fe0) begin
            n_bad++;
            $display("FAIL glitch_pulses got dv=%0d fe=%0d expected 0 0", dv_cnt_a - dv0, fe_cnt_a - fe0);
        end
        n_cmp++;
        if (data_a !== 8'hFF) begin
            n_bad++;
            $display("FAIL glitch_data got=%h expected=ff", data_a);
        end
    endtask

    task automatic test_frame_err;
        int dv0, fe0;
        dv0 = dv_cnt_a;
        fe0 = fe_cnt_a;
        send_a(8'hA5, 16, 1'b0);
        rx_a = 1'b0;
        hold_bit(100);
        rx_a = 1'b1;
        hold_bit(20);
        n_cmp++;
        if (fe_cnt_a - fe0 != 1 || dv_cnt_a != dv0) begin
            n_bad++;
            $display("FAIL ferr_pulses got fe=%0d dv=%0d expected 1 0", fe_cnt_a - fe0, dv_cnt_a - dv0);
        end
        n_cmp++;
        if (data_a !== 8'hFF || busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL ferr_hold got data=%h busy=%b expected ff 0", data_a, busy_a);
        end
        send_a(8'h5A, 16, 1'b1);
        hold_bit(20);
        n_cmp++;
        if (data_a !== 8'h5A) begin
            n_bad++;
            $display("FAIL ferr_next got=%h expected=5a", data_a);
        end
    endtask

    task automatic test_reset_mid_frame;
        int dv0;
        logic [7:0] b;
        b = 8'h77;
        dv0 = dv_cnt_a;
        rx_a = 1'b0;
        hold_bit(16);
        for (int i = 0; i < 3; i++) begin
            rx_a = b[i];
            hold_bit(16);
        end
        rx_a = b[3];
        hold_bit(8);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (data_a !== 8'h00 || busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid got data=%h busy=%b expected 00 0", data_a, busy_a);
        end
        rx_a = 1'b1;
        hold_bit(4);
        rst_n = 1'b1;
        hold_bit(10);
        send_a(8'h12, 16, 1'b1);
        hold_bit(20);
        n_cmp++;
        if (data_a !== 8'h12 || dv_cnt_a - dv0 != 1) begin
            n_bad++;
            $display("FAIL rst_after got data=%h pulses=%0d expected 12 1", data_a, dv_cnt_a - dv0);
        end
    endtask

    task automatic test_baud_tolerance;
        int dv0;
        dv0 = dv_cnt_b;
        send_b(8'h41, 211);
        hold_bit(50);
        n_cmp++;
        if (data_b !== 8'h41 || dv_cnt_b - dv0 != 1) begin
            n_bad++;
            $display("FAIL baud_fast got data=%h pulses=%0d expected 41 1", data_b, dv_cnt_b - dv0);
        end
        send_b(8'h41, 223);
        hold_bit(50);
        n_cmp++;
        if (data_b !== 8'h41 || dv_cnt_b - dv0 != 2 || fe_cnt_b != 0) begin
            n_bad++;
            $display("FAIL baud_slow got data=%h pulses=%0d fe=%0d expected 41 2 0", data_b, dv_cnt_b - dv0, fe_cnt_b);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_mid_frame;
        test_baud_tolerance;
        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover got a=%0d b=%0d expected 0 0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
